// File: rtl/dark_debug_uart_tx_if.sv
// Debug-bus bundle between the datapath group (master) and the debug UART reader (slave).
// Carries the four debug words, the snapshot request and the UART status/pin.
interface dark_debug_uart_tx_if;
    logic [3:0][31:0] DEBUG;
    logic             TRIG;
    logic             BUSY;
    logic             TXD;

    modport master (
        output DEBUG,
        output TRIG,
        input  BUSY,
        input  TXD
    );

    modport slave (
        input  DEBUG,
        input  TRIG,
        output BUSY,
        output TXD
    );
endinterface

// File: rtl/dark_debug_uart_tx.sv
// Snapshots the 4x32 DEBUG bus on a trigger and sends it as "W0 W1 W2 W3\r\n" in ASCII hex over 8N1.
// Optional DARK_DBGTX_CHANGE_EN: auto-trigger in IDLE whenever DEBUG differs from the last line sent.
module dark_debug_uart_tx #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic                XCLK,
    input  logic                XRES,
    dark_debug_uart_tx_if.slave dbg
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_START  = 2'd1;
    localparam logic [1:0]  ST_DATA   = 2'd2;
    localparam logic [1:0]  ST_STOP   = 2'd3;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [5:0]  LAST_CHAR = 6'd36;

    logic [1:0]       state_q, state_d;
    logic [15:0]      baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [5:0]       char_idx_q, char_idx_d;
    logic [3:0][31:0] snap_q, snap_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;

    logic             auto_trig;
    logic             trig_any;
    logic             baud_done;
    logic [1:0]       word_sel;
    logic [3:0]       nib_pos;
    logic [31:0]      word_val;
    logic [3:0]       nibble;
    logic [7:0]       cur_char;

    // The snapshot doubles as the "last transmitted" reference for change detection.
`ifdef DARK_DBGTX_CHANGE_EN
    assign auto_trig = (dbg.DEBUG != snap_q);
`else
    assign auto_trig = 1'b0;
`endif

    assign trig_any  = dbg.TRIG | auto_trig;
    assign baud_done = (baud_cnt_q == BAUD_LAST);

    // Each word occupies 9 character slots: 8 hex digits then a separator slot.
    always_comb begin
        word_sel = 2'd0;
        nib_pos  = char_idx_q[3:0];
        if (char_idx_q >= 6'd27) begin
            word_sel = 2'd3;
            nib_pos  = 4'(char_idx_q - 6'd27);
        end else if (char_idx_q >= 6'd18) begin
            word_sel = 2'd2;
            nib_pos  = 4'(char_idx_q - 6'd18);
        end else if (char_idx_q >= 6'd9) begin
            word_sel = 2'd1;
            nib_pos  = 4'(char_idx_q - 6'd9);
        end
        word_val = snap_q[word_sel];
        nibble   = 4'(word_val >> {3'd7 - nib_pos[2:0], 2'b00});

        if (char_idx_q == LAST_CHAR) begin
            cur_char = 8'h0A;
        end else if (char_idx_q == 6'd35) begin
            cur_char = 8'h0D;
        end else if (nib_pos == 4'd8) begin
            cur_char = 8'h20;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h37 + {4'h0, nibble};
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_done ? 16'd0 : baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        char_idx_d = char_idx_q;
        snap_d     = snap_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = 16'd0;
                if (trig_any) begin
                    state_d    = ST_START;
                    snap_d     = dbg.DEBUG;
                    busy_d     = 1'b1;
                    char_idx_d = 6'd0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (char_idx_q == LAST_CHAR) begin
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        char_idx_d = 6'd0;
                    end else begin
                        state_d    = ST_START;
                        char_idx_d = char_idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = 16'd0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // TXD is registered from the current state, so the pin trails the FSM by exactly one cycle.
    always_comb begin
        case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = cur_char[bit_cnt_q];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            char_idx_q <= 6'd0;
            snap_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            char_idx_q <= char_idx_d;
            snap_q     <= snap_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign dbg.BUSY = busy_q;
    assign dbg.TXD  = txd_q;

endmodule
